// File: rtl/stack_prog_sequencer_pkg.sv
// rtl/stack_prog_sequencer_pkg.sv - opcode, state and exec-length constants for the program sequencer
package stack_prog_sequencer_pkg;

  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_OUTL = 4'h3;
  localparam logic [3:0] OP_END  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_FETCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // Cycles the calculator spends executing each opcode after its fetch cycle.
  function automatic logic [1:0] exec_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: exec_len = 2'd2;
      4'h9, 4'hA:                         exec_len = 2'd3;
      default:                            exec_len = 2'd1;
    endcase
  endfunction

  function automatic logic has_operand(input logic [3:0] op);
    case (op)
      4'h1, 4'h6, 4'h7, 4'h8: has_operand = 1'b1;
      default:                has_operand = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stack_prog_sequencer_if.sv
// rtl/stack_prog_sequencer_if.sv - load/start controls and calculator-facing outputs of the sequencer
interface stack_prog_sequencer_if #(
  parameter int AW = 4
);
  logic          load_en;
  logic [3:0]    load_data;
  logic          start;
  logic [3:0]    nib_out;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          load_ovf;
  logic [AW-1:0] pc;
  logic [AW:0]   prog_len;

  modport master (
    output load_en, load_data, start,
    input  nib_out, cpu_rst, busy, done, load_ovf, pc, prog_len
  );

  modport slave (
    input  load_en, load_data, start,
    output nib_out, cpu_rst, busy, done, load_ovf, pc, prog_len
  );
endinterface

// File: rtl/stack_prog_sequencer_mem.sv
// rtl/stack_prog_sequencer_mem.sv - seq_prog_mem: DEPTHx4 program register file, one write port, two async reads
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_data,
  input  logic [AW-1:0] rd_addr_a,
  output logic [3:0]    rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [3:0]    rd_data_b
);
  logic [3:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
endmodule

// File: rtl/stack_prog_sequencer.sv
// rtl/stack_prog_sequencer.sv - plays a loaded nibble program into the stack calculator; SEQ_LOOP_EN replays it forever
module stack_prog_sequencer
  import stack_prog_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic clk,
  input  logic rst,
  stack_prog_sequencer_if.slave bus
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] TWO  = (AW+1)'(2);

  seq_state_t  state_q, state_d;
  logic [AW:0] pc_q, pc_d, len_q, len_d;
  logic [1:0]  k_q, k_d;
  logic [3:0]  nib_q, nib_d;
  logic        ovf_q, ovf_d;
  logic        opnd_q, opnd_d;
  logic        wr_en, loop_wrap;

  logic [AW:0] adv, fetch_addr, pc_plus1;
  logic [3:0]  rd_data_a, rd_data_b, fetch_nib, opnd_nib;
  logic        end_run;

  // Port A looks at the address the next FETCH will present, so nib_out can be
  // registered and still show the opcode during the fetch cycle itself.
  assign adv        = opnd_q ? TWO : ONE;
  assign fetch_addr = (state_q == ST_EXEC) ? pc_q + adv : pc_q;
  assign pc_plus1   = pc_q + ONE;
  assign fetch_nib  = (fetch_addr < len_q) ? rd_data_a : 4'h0;
  assign opnd_nib   = (pc_plus1 < len_q) ? rd_data_b : 4'h0;
  assign end_run    = (pc_q >= len_q) || (rd_data_a == OP_END);

  seq_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk       (clk),
    .we        (wr_en),
    .wr_addr   (len_q[AW-1:0]),
    .wr_data   (bus.load_data),
    .rd_addr_a (fetch_addr[AW-1:0]),
    .rd_data_a (rd_data_a),
    .rd_addr_b (pc_plus1[AW-1:0]),
    .rd_data_b (rd_data_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      k_q     <= '0;
      nib_q   <= '0;
      ovf_q   <= 1'b0;
      opnd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      k_q     <= k_d;
      nib_q   <= nib_d;
      ovf_q   <= ovf_d;
      opnd_q  <= opnd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    k_d       = k_q;
    nib_d     = nib_q;
    ovf_d     = ovf_q;
    opnd_d    = opnd_q;
    wr_en     = 1'b0;
    loop_wrap = 1'b0;

    case (state_q)
      ST_IDLE: begin
        nib_d = 4'h0;
        if (bus.load_en) begin
          if (len_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            len_d = len_q + ONE;
          end
        end else if (bus.start) begin
          pc_d    = '0;
          state_d = (len_q == '0) ? ST_DONE : ST_CRST;
        end
      end
      ST_CRST: begin
        state_d = ST_FETCH;
        nib_d   = fetch_nib;
      end
      ST_FETCH: begin
        if (end_run) begin
          nib_d = 4'h0;
`ifdef SEQ_LOOP_EN
          loop_wrap = 1'b1;
          pc_d      = '0;
          state_d   = ST_CRST;
`else
          state_d   = ST_DONE;
`endif
        end else begin
          state_d = ST_EXEC;
          k_d     = exec_len(rd_data_a);
          opnd_d  = has_operand(rd_data_a);
          nib_d   = has_operand(rd_data_a) ? opnd_nib : 4'h0;
        end
      end
      ST_EXEC: begin
        if (k_q == 2'd1) begin
          state_d = ST_FETCH;
          pc_d    = fetch_addr;
          nib_d   = fetch_nib;
        end else begin
          k_d = k_q - 2'd1;
        end
      end
      ST_DONE: begin
        nib_d = 4'h0;
        if (bus.start) begin
          pc_d    = '0;
          state_d = ST_CRST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        nib_d   = 4'h0;
      end
    endcase
  end

  assign bus.nib_out  = nib_q;
  assign bus.cpu_rst  = (state_q == ST_CRST);
  assign bus.busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done     = (state_q == ST_DONE) || loop_wrap;
  assign bus.load_ovf = ovf_q;
  assign bus.pc       = pc_q[AW-1:0];
  assign bus.prog_len = len_q;
endmodule

// File: tb/tb_stack_prog_sequencer.sv
// tb/tb_stack_prog_sequencer.sv - randomized and directed bench for stack_prog_sequencer against a program-walk model
module tb_stack_prog_sequencer;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_prog_sequencer_if #(.AW(AW)) bus();

  stack_prog_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int prog[$];
  int exp_q[$];
  int exp_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.load_en = 1'b0;
    bus.start = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_nib", bus.nib_out, 0);
    check("rst_cpu_rst", bus.cpu_rst, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.load_ovf, 0);
    check("rst_pc", bus.pc, 0);
    check("rst_len", bus.prog_len, 0);
  endtask

  task automatic load_prog();
    foreach (prog[i]) begin
      bus.load_en = 1'b1;
      bus.load_data = prog[i][3:0];
      tick();
    end
    bus.load_en = 1'b0;
    check("load_len", bus.prog_len, (prog.size() > DEPTH) ? DEPTH : prog.size());
    check("load_ovf", bus.load_ovf, (prog.size() > DEPTH) ? 1 : 0);
  endtask

  // Walks the stored program as the calculator would see it: a reset cycle,
  // then each opcode followed by its execute cycles, until END or the program runs out.
  task automatic build_expect();
    int len, pc, op, k;
    bit operand;
    len = (prog.size() > DEPTH) ? DEPTH : prog.size();
    exp_q = {};
    pc = 0;
    exp_pc = 0;
    if (len == 0) return;
    exp_q.push_back(0);
    while (1) begin
      if (pc >= len || prog[pc] == 15) begin
        exp_q.push_back((pc < len) ? prog[pc] : 0);
        break;
      end
      op = prog[pc];
      if (op inside {1, 2, 5, 6, 7, 8}) k = 2;
      else if (op == 9 || op == 10) k = 3;
      else k = 1;
      operand = op inside {1, 6, 7, 8};
      exp_q.push_back(op);
      repeat (k) exp_q.push_back(operand ? ((pc + 1 < len) ? prog[pc + 1] : 0) : 0);
      pc += operand ? 2 : 1;
    end
    exp_pc = pc;
  endtask

  // Entered on the cycle right after start was sampled (the calculator reset cycle).
  task automatic check_pass(input string tag);
    foreach (exp_q[i]) begin
      check({tag, "_nib"}, bus.nib_out, exp_q[i]);
      check({tag, "_cpu_rst"}, bus.cpu_rst, (i == 0) ? 1 : 0);
      check({tag, "_busy"}, bus.busy, 1);
`ifdef SEQ_LOOP_EN
      check({tag, "_done_pulse"}, bus.done, (i == exp_q.size() - 1) ? 1 : 0);
`else
      check({tag, "_done_run"}, bus.done, 0);
`endif
      tick();
    end
`ifndef SEQ_LOOP_EN
    check({tag, "_end_done"}, bus.done, 1);
    check({tag, "_end_busy"}, bus.busy, 0);
    check({tag, "_end_nib"}, bus.nib_out, 0);
    check({tag, "_end_pc"}, bus.pc, exp_pc % DEPTH);
`endif
  endtask

  task automatic run(input string tag);
    build_expect();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_done"}, bus.done, 1);
      check({tag, "_empty_busy"}, bus.busy, 0);
      check({tag, "_empty_cpu_rst"}, bus.cpu_rst, 0);
      return;
    end
    check_pass(tag);
`ifdef SEQ_LOOP_EN
    check_pass({tag, "_pass2"});
`endif
  endtask

  initial begin
    int len;
    rst = 1'b1;
    bus.load_en = 1'b0;
    bus.load_data = 4'h0;
    bus.start = 1'b0;
    tick();

    do_reset();
    prog = '{1, 5, 3};
    load_prog();
    run("push_outl");
`ifndef SEQ_LOOP_EN
    run("rerun");
    bus.load_en = 1'b1;
    bus.load_data = 4'h7;
    tick();
    bus.load_en = 1'b0;
    check("done_load_len", bus.prog_len, 3);
    check("done_load_done", bus.done, 1);
`endif

    do_reset();
    prog = '{9, 15, 1, 2};
    load_prog();
    run("end_code");

    do_reset();
    prog = '{8};
    load_prog();
    run("trunc_opnd");

    do_reset();
    prog = '{3, 4, 0, 11, 12, 13, 14, 3, 4, 0, 11, 12, 13, 14, 3, 4, 15};
    load_prog();
    run("overflow");

    do_reset();
    prog = '{10, 3};
    load_prog();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("abort_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_nib", bus.nib_out, 0);
    check("abort_busy_clr", bus.busy, 0);
    check("abort_pc", bus.pc, 0);
    check("abort_len", bus.prog_len, 0);
    prog = {};
    run("abort_empty");
    do_reset();
    prog = '{10, 3};
    load_prog();
    run("abort_reload");

    do_reset();
    bus.load_en = 1'b1;
    bus.load_data = 4'h3;
    bus.start = 1'b1;
    tick();
    bus.load_en = 1'b0;
    bus.start = 1'b0;
    check("ld_start_len", bus.prog_len, 1);
    check("ld_start_busy", bus.busy, 0);
    check("ld_start_done", bus.done, 0);

    do_reset();
    prog = '{1, 3, 3};
    load_prog();
    run("loop_prog");

    for (int t = 0; t < 40; t++) begin
      do_reset();
      len = $urandom_range(0, 18);
      prog = {};
      for (int j = 0; j < len; j++)
        prog.push_back(($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 14)));
      load_prog();
      run($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/stack_prog_sequencer.md
# stack_prog_sequencer

Upstream program feeder for the 4-bit stack calculator. It stores a short nibble program loaded serially, then plays it back onto the calculator's 4-bit instruction/operand input (`inbits`), one nibble per cycle. Each opcode and its operand are held for exactly the cycle count the calculator consumes. Before each run it also pulses the calculator's reset, so a program always starts from a clean stack and clean flags.

## Interface
Parameters:
- `DEPTH`, default 16: number of nibbles in program memory.
- `AW`, default 4: address width; `DEPTH` equals 2**`AW`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `load_en`  in  1  write strobe; stores `load_data` at the load pointer.
- `load_data`  in  4  program nibble to store.
- `start`  in  1  begin playback; accepted only in IDLE.
- `nib_out`  out  4  drives the calculator's `inbits`.
- `cpu_rst`  out  1  drives the calculator's reset.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high while in DONE.
- `load_ovf`  out  1  sticky; set by a write attempted when memory is full.
- `pc`  out  AW  address of the current opcode.
- `prog_len`  out  AW+1  number of nibbles loaded.

## Operation
- States: IDLE, CRST, FETCH, EXEC, DONE.
- Reset values: all outputs 0; state is IDLE. `prog_len` clears to 0. Memory contents are not cleared.
- Loading, IDLE only:
  - `load_en` writes `mem[prog_len]` and increments `prog_len`.
  - When `prog_len == DEPTH`, the write is dropped and `load_ovf` is set.
  - `load_en` in any other state is ignored.
- Start rules:
  - `start` in IDLE with `prog_len > 0` goes to CRST.
  - `start` in IDLE with `prog_len == 0` goes straight to DONE.
  - If `load_en` and `start` are high in the same cycle, the load is performed and `start` is ignored.
- CRST, 1 cycle: `cpu_rst=1`, `nib_out=0`, `pc` set to 0. Next state is FETCH.
- FETCH, 1 cycle: `nib_out=mem[pc]`.
  - If the opcode is 0xF, or `pc >= prog_len`, go to DONE.
  - Otherwise load the exec counter `k` from the table below and go to EXEC.
- Execute lengths `k` by opcode:
  - 1, 2, 5, 6, 7, 8: `k=2`.
  - 9, A: `k=3`.
  - 0, 3, 4, B, C, D, E: `k=1`.
- Operand opcodes are 1, 6, 7 and 8.
  - During EXEC, `nib_out` is `mem[pc+1]` for an operand opcode, otherwise 0.
  - If the operand address equals `prog_len` (truncated program), the operand presented is 0.
- EXEC lasts `k` cycles. On its last cycle, `pc` advances by 2 for an operand opcode, otherwise by 1, and the next state is FETCH.
- DONE: `nib_out=0`.
  - `start` goes back to CRST (rerun the program).
  - `load_en` is ignored.
  - The next `rst` clears `prog_len` so a new program can be loaded.
- `pc` never wraps. Any advance reaching or passing `prog_len` ends the run at the next FETCH.
- `rst` mid-run aborts immediately to IDLE. The calculator is re-reset by the next CRST.

## Timing
- CRST is the only cycle with `cpu_rst=1`. The FETCH that follows on the next cycle is the calculator's fetch cycle.
- FETCH and EXEC alternate with no gap, so the sequencer always matches the calculator's fetch/execute cadence.
- Latency from `start` sampled to the first opcode on `nib_out` is 2 cycles (CRST, then FETCH).
- `nib_out` is registered. `mem` is read combinationally at `pc` and `pc+1`.

## Configuration
- `SEQ_LOOP_EN`:
  - Defined: on reaching DONE's entry condition, the sequencer instead goes to CRST and replays from `pc=0`. `done` pulses high for that one transition cycle; `busy` stays high. The loop stops only on `rst`.
  - Undefined: the sequencer ends in DONE as described above.

## Structure
- Opcode values, the END code (0xF), state encodings and the exec-length table go in the shared constants include, alongside the calculator's opcode constants.
- Sub-module `seq_prog_mem`: a `DEPTH`x4 register file with synchronous write and two asynchronous read ports (`pc`, `pc+1`). It has no reset.

## Test plan
- Load 1,5,3 (PUSH 5, OUTL), then `start`:
  - `cpu_rst` high for 1 cycle.
  - `nib_out` sequence 1,5,5,3,0, then DONE with `pc=3`.
- Load 9,F,1,2: `nib_out` is 9,0,0,0,F, then DONE. The nibbles 1,2 after the END opcode are never emitted.
- Load 8 only (truncated operand): `nib_out` is 8,0,0, then DONE. No out-of-range read.
- Write 17 nibbles: `prog_len=16`, `load_ovf=1`, and `mem[0..15]` is unchanged by the 17th write.
- Assert `rst` during EXEC of opcode A: next cycle is IDLE with all outputs 0. A following `start` replays from `pc=0` only after reloading the program, because `rst` cleared `prog_len`.
- With `SEQ_LOOP_EN`, load 1,3,3: the 1,3,3,3 sequence repeats with a 1-cycle `cpu_rst` between passes, and `done` pulses once per pass.
